pattern_scan_ctrl: RTL and testbench
====================================

# pattern_scan_ctrl

Sequencer for the serial pattern detector (`pattern`). It captures a parallel data word and a target pattern, then drives the detector's load and serial inputs: one load pulse, then the word MSB-first, one bit per clock. It counts the detector's match pulses, including overlapping matches, and reports the count and the position of the first match with a one-cycle `done` pulse. It sits between a register/host interface and the detector instance.

## Interface
- `DATA_W`, 16, width of the scanned word.
- `PAT_W`, 5, pattern width; must equal the detector's `patternIn` width.
- `CNT_W`, $clog2(DATA_W+1), width of the count and position outputs.
- `DET_LAT`, 1, cycles from a bit being driven on `det_serial` to the corresponding `det_patt` response (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a scan; sampled only in IDLE.
- `pattern_cfg`  in  PAT_W  target pattern, captured on the accepted start.
- `data_in`  in  DATA_W  word to scan, captured on the accepted start.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `found`  out  1  at least one match occurred.
- `match_count`  out  CNT_W  number of matches, overlapping ones included.
- `first_pos`  out  CNT_W  bit index (0 = MSB) of the last bit of the first match; `DATA_W` if no match.
- `det_load`  out  1  drives detector `load`.
- `det_pattern`  out  PAT_W  drives detector `patternIn`.
- `det_serial`  out  1  drives detector `serial_in`.
- `det_patt`  in  1  detector `patt` output.

## Operation
- **States:** IDLE, LOAD, SHIFT, DRAIN, DONE.
- **IDLE:**
  - On `start`=1, capture `data_in` into the shift register and `pattern_cfg` into the pattern register.
  - Clear the bit index, `match_count`, `found`, and the valid pipeline. Go to LOAD.
- **LOAD:** one cycle. `det_load`=1, `det_pattern`=captured pattern, `det_serial`=0. The detector contract is that load also clears its bit history. Go to SHIFT.
- **SHIFT:**
  - Runs exactly DATA_W cycles. `det_serial` = shift-register MSB; the register shifts left each cycle.
  - The bit index runs 0..DATA_W-1. A valid bit (1) and its index enter a DET_LAT-deep delay pipeline.
  - After index DATA_W-1, go to DRAIN.
- **DRAIN:** DET_LAT cycles with `det_serial`=0 and 0 pushed into the valid pipeline. Then go to DONE.
- **Match accounting:**
  - In any cycle where the pipeline output valid=1 and `det_patt`=1, increment `match_count`.
  - On the first such event, set `found`=1 and `first_pos` to the delayed index.
  - `det_patt` is ignored whenever the delayed valid is 0. This covers LOAD and matches caused by drain zeros.
- **DONE:**
  - `done`=1 for one cycle, then go to IDLE.
  - `found`, `match_count` and `first_pos` hold until the next accepted start clears them.
  - When no match occurred, `first_pos` is set to DATA_W.
- **Width rule:** the maximum count is DATA_W-PAT_W+1, which fits in CNT_W. No saturation is needed.
- **Start while busy:** ignored. It is not queued, and the captured registers do not change.
- **Start during DONE:** ignored. A start is accepted only in IDLE, i.e. the cycle after DONE at the earliest.
- **`pattern_cfg`/`data_in` changes after capture:** no effect on the scan in progress.
- **Reset mid-operation:** state becomes IDLE on the next edge, all outputs return to reset values, and no `done` is issued.
- **Detector reset:** the detector's `reset_n` is driven from the inverse of `reset` at the top level.

## Timing
- **Reset values:** `busy`=0, `done`=0, `found`=0, `match_count`=0, `first_pos`=0, `det_load`=0, `det_pattern`=0, `det_serial`=0.
- **Cycle schedule**, with start sampled at edge 0:
  - LOAD in cycle 1.
  - SHIFT in cycles 2..DATA_W+1.
  - DRAIN in cycles DATA_W+2..DATA_W+1+DET_LAT.
  - DONE in cycle DATA_W+2+DET_LAT (19 for the defaults).
- **Turnaround:** the next start can be accepted DATA_W+3+DET_LAT cycles after the previous one.
- **Outputs:** all registered; none depends combinationally on any input.

## Test plan
The bench uses a behavioural detector model: a PAT_W-bit shift register cleared by load, with `patt` registered (DET_LAT=1) and overlapping matches detected.

1. Reset held for 3 cycles → all outputs 0; `start` pulsed during reset is ignored.
2. `pattern_cfg`=5'b11011, `data_in`=16'hDB00 → `det_load` pulses in cycle 1; `done` in cycle 19; `match_count`=2, `first_pos`=4, `found`=1.
3. `pattern_cfg`=5'b11011, `data_in`=16'h0000 → `match_count`=0, `found`=0, `first_pos`=16. Then `pattern_cfg`=5'b00000 with the same data → `match_count`=12 (drain zeros not counted), `first_pos`=4.
4. `pattern_cfg`=5'b11111, `data_in`=16'hFFFF → `match_count`=12, `first_pos`=4. Then `data_in`=16'h001F → `match_count`=1, `first_pos`=15.
5. Start re-pulsed in SHIFT and in DONE with a different config → ignored; results match the first config. Start one cycle after `done` is accepted and `done` follows 19 cycles later.
6. Reset asserted in SHIFT cycle 8 → IDLE next cycle, `busy`=0, `det_load`=0, results 0, no `done` within the following 30 cycles.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Scan sequencer for the serial pattern detector: loads the detector, streams a
// captured word MSB-first, and tallies the detector's (overlapping) match pulses.
module pattern_scan_ctrl #(
  parameter int DATA_W  = 16,
  parameter int PAT_W   = 5,
  parameter int CNT_W   = $clog2(DATA_W + 1),
  parameter int DET_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PAT_W-1:0]  pattern_cfg,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  first_pos,
  output logic              det_load,
  output logic [PAT_W-1:0]  det_pattern,
  output logic              det_serial,
  input  logic              det_patt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DRN_W = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] NO_MATCH  = CNT_W'(DATA_W);
  localparam logic [DRN_W-1:0] LAST_DRN  = DRN_W'(DET_LAT - 1);

  state_t             state_q;
  logic [DATA_W-1:0]  shift_q;
  logic [CNT_W-1:0]   bit_idx_q;
  logic [DRN_W-1:0]   drain_cnt_q;
  logic [DET_LAT-1:0] vld_pipe_q;
  logic [CNT_W-1:0]   idx_pipe_q [DET_LAT];

  logic               busy_q;
  logic               done_q;
  logic               found_q;
  logic [CNT_W-1:0]   match_count_q;
  logic [CNT_W-1:0]   first_pos_q;
  logic               det_load_q;
  logic [PAT_W-1:0]   det_pattern_q;
  logic               det_serial_q;

  // A detector response only counts when it lines up with a real data bit.
  logic hit;
  assign hit = vld_pipe_q[DET_LAT-1] & det_patt;

  // NOTE: one clocked block with non-blocking assignments only; an assignment
  // later in the block overrides an earlier one for the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      bit_idx_q     <= '0;
      drain_cnt_q   <= '0;
      vld_pipe_q    <= '0;
      for (int k = 0; k < DET_LAT; k++) idx_pipe_q[k] <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      match_count_q <= '0;
      first_pos_q   <= '0;
      det_load_q    <= 1'b0;
      det_pattern_q <= '0;
      det_serial_q  <= 1'b0;
    end else begin
      for (int k = 1; k < DET_LAT; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        idx_pipe_q[k] <= idx_pipe_q[k-1];
      end
      vld_pipe_q[0] <= (state_q == S_SHIFT);
      idx_pipe_q[0] <= bit_idx_q;

      if (hit) begin
        match_count_q <= match_count_q + 1'b1;
        if (!found_q) begin
          found_q     <= 1'b1;
          first_pos_q <= idx_pipe_q[DET_LAT-1];
        end
      end

      done_q     <= 1'b0;
      det_load_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            shift_q       <= data_in;
            det_pattern_q <= pattern_cfg;
            bit_idx_q     <= '0;
            match_count_q <= '0;
            found_q       <= 1'b0;
            // Stays at the no-match value unless a match overwrites it.
            first_pos_q   <= NO_MATCH;
            vld_pipe_q    <= '0;
            busy_q        <= 1'b1;
            det_load_q    <= 1'b1;
            det_serial_q  <= 1'b0;
            state_q       <= S_LOAD;
          end
        end

        S_LOAD: begin
          det_serial_q <= shift_q[DATA_W-1];
          shift_q      <= shift_q << 1;
          bit_idx_q    <= '0;
          state_q      <= S_SHIFT;
        end

        S_SHIFT: begin
          if (bit_idx_q == LAST_IDX) begin
            det_serial_q <= 1'b0;
            drain_cnt_q  <= '0;
            state_q      <= S_DRAIN;
          end else begin
            det_serial_q <= shift_q[DATA_W-1];
            shift_q      <= shift_q << 1;
            bit_idx_q    <= bit_idx_q + 1'b1;
          end
        end

        S_DRAIN: begin
          if (drain_cnt_q == LAST_DRN) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign match_count = match_count_q;
  assign first_pos   = first_pos_q;
  assign det_load    = det_load_q;
  assign det_pattern = det_pattern_q;
  assign det_serial  = det_serial_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl with a behavioural detector attached
// and a sliding-window reference model of the expected scan results.
module tb_pattern_scan_ctrl;

  localparam int DATA_W  = 16;
  localparam int PAT_W   = 5;
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int DET_LAT = 1;
  localparam int DONE_LAT = DATA_W + 1 + DET_LAT;  // edges from start edge to done visible

  logic              clk;
  logic              reset;
  logic              start;
  logic [PAT_W-1:0]  pattern_cfg;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done;
  logic              found;
  logic [CNT_W-1:0]  match_count;
  logic [CNT_W-1:0]  first_pos;
  logic              det_load;
  logic [PAT_W-1:0]  det_pattern;
  logic              det_serial;
  logic              det_patt;

  pattern_scan_ctrl #(
    .DATA_W (DATA_W),
    .PAT_W  (PAT_W),
    .CNT_W  (CNT_W),
    .DET_LAT(DET_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern_cfg(pattern_cfg),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .match_count(match_count),
    .first_pos  (first_pos),
    .det_load   (det_load),
    .det_pattern(det_pattern),
    .det_serial (det_serial),
    .det_patt   (det_patt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Detector: history cleared by load, needs PAT_W fresh bits before matching.
  logic [PAT_W-1:0] det_hist;
  logic [PAT_W-1:0] det_pat_r;
  int               det_fill;
  always @(posedge clk) begin
    if (reset) begin
      det_hist  <= '0;
      det_pat_r <= '0;
      det_fill  <= 0;
      det_patt  <= 1'b0;
    end else if (det_load) begin
      det_hist  <= '0;
      det_pat_r <= det_pattern;
      det_fill  <= 0;
      det_patt  <= 1'b0;
    end else begin
      det_hist <= {det_hist[PAT_W-2:0], det_serial};
      if (det_fill < PAT_W) det_fill <= det_fill + 1;
      det_patt <= (det_fill >= PAT_W - 1) &&
                  ({det_hist[PAT_W-2:0], det_serial} == det_pat_r);
    end
  end

  typedef struct {
    int found;
    int count;
    int first;
    int start_edge;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_scan(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p,
                                   output int cnt, output int first);
    logic bits [DATA_W];
    logic ok;
    cnt   = 0;
    first = DATA_W;
    for (int j = 0; j < DATA_W; j++) bits[j] = d[DATA_W-1-j];
    for (int i = PAT_W - 1; i < DATA_W; i++) begin
      ok = 1'b1;
      for (int k = 0; k < PAT_W; k++)
        if (bits[i-PAT_W+1+k] != p[PAT_W-1-k]) ok = 1'b0;
      if (ok) begin
        cnt++;
        if (first == DATA_W) first = i;
      end
    end
  endfunction

  // Monitor: every done pulse is matched against the oldest expected scan.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      check("done_pulse_width", {31'b0, prev_done}, 0);
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("found", {31'b0, found}, mon_e.found);
        check("match_count", {27'b0, match_count}, mon_e.count);
        check("first_pos", {27'b0, first_pos}, mon_e.first);
        check("done_latency", edge_cnt - mon_e.start_edge, DONE_LAT);
      end
    end
    prev_done <= done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p, input bit accepted);
    int cnt;
    int first;
    data_in     = d;
    pattern_cfg = p;
    start       = 1'b1;
    tick(1);
    start = 1'b0;
    if (accepted) begin
      ref_scan(d, p, cnt, first);
      sb.push_back('{(cnt > 0) ? 1 : 0, cnt, first, edge_cnt});
      check("load_pulse", {31'b0, det_load}, 1);
      check("load_pattern", {27'b0, det_pattern}, {27'b0, p});
      check("busy_on_start", {31'b0, busy}, 1);
    end
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (sb.size() != 0 && i < budget) begin
      tick(1);
      i++;
    end
    if (sb.size() != 0) begin
      check("done_timeout_pending", sb.size(), 0);
      sb.delete();
    end
    tick(1);
  endtask

  logic [DATA_W-1:0] rd;
  logic [PAT_W-1:0]  rp;
  int                pos;

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    data_in     = '0;
    pattern_cfg = '0;

    // Reset held three cycles with a start request present.
    start       = 1'b1;
    data_in     = 16'hFFFF;
    pattern_cfg = 5'h1F;
    tick(3);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_found", {31'b0, found}, 0);
    check("rst_match_count", {27'b0, match_count}, 0);
    check("rst_first_pos", {27'b0, first_pos}, 0);
    check("rst_det_load", {31'b0, det_load}, 0);
    check("rst_det_pattern", {27'b0, det_pattern}, 0);
    check("rst_det_serial", {31'b0, det_serial}, 0);
    start = 1'b0;
    reset = 1'b0;
    tick(2);
    check("idle_after_rst_busy", {31'b0, busy}, 0);
    check("idle_after_rst_load", {31'b0, det_load}, 0);

    // Directed scans.
    issue(16'hDB00, 5'b11011, 1'b1);
    tick(1);
    check("load_one_cycle", {31'b0, det_load}, 0);
    wait_idle(40);
    issue(16'h0000, 5'b11011, 1'b1);
    wait_idle(40);
    issue(16'h0000, 5'b00000, 1'b1);
    wait_idle(40);
    issue(16'hFFFF, 5'b11111, 1'b1);
    wait_idle(40);
    issue(16'h001F, 5'b11111, 1'b1);
    wait_idle(40);

    // Starts in SHIFT and in DONE are dropped; the one after DONE is taken.
    issue(16'hDB00, 5'b11011, 1'b1);
    tick(5);
    issue(16'hFFFF, 5'b11111, 1'b0);
    tick(12);
    check("in_done_state", {31'b0, done}, 1);
    issue(16'hFFFF, 5'b11111, 1'b0);
    issue(16'h001F, 5'b11111, 1'b1);
    wait_idle(40);

    // Reset in SHIFT cycle 8 after a match has already been recorded.
    issue(16'hDB00, 5'b11011, 1'b1);
    tick(7);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sb.delete();
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_det_load", {31'b0, det_load}, 0);
    check("abort_det_serial", {31'b0, det_serial}, 0);
    check("abort_found", {31'b0, found}, 0);
    check("abort_match_count", {27'b0, match_count}, 0);
    check("abort_first_pos", {27'b0, first_pos}, 0);
    tick(30);
    check("abort_still_idle", {31'b0, busy}, 0);

    // Random scans, half with the pattern planted somewhere in the word.
    for (int n = 0; n < 24; n++) begin
      rd = DATA_W'($urandom);
      rp = PAT_W'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        pos = $urandom_range(0, DATA_W - PAT_W);
        rd[DATA_W-1-pos -: PAT_W] = rp;
      end
      issue(rd, rp, 1'b1);
      tick($urandom_range(0, 10));
      if ($urandom_range(0, 1) == 1) issue(~rd, ~rp, 1'b0);
      data_in     = DATA_W'($urandom);
      pattern_cfg = PAT_W'($urandom);
      wait_idle(40);
      tick($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
